// File: rtl/abr_be_ram_arb_if.sv
// -----------------------------------------------------------------------------
// abr_be_ram_arb_if
// Bundles the requester-side and RAM-side signals of abr_be_ram_arb.
//   slave  : arbiter view (requests/payloads and ram_rdata_i in; grants,
//            read return and RAM command out)
//   master : environment view (requesters plus the shared RAM)
// Requester k occupies slice k of every packed per-requester vector.
// -----------------------------------------------------------------------------
interface abr_be_ram_arb_if #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STROBE_WIDTH = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned NSTRB      = DATA_WIDTH / STROBE_WIDTH;

  logic [NUM_REQ-1:0]            wr_req_i;
  logic [NUM_REQ*NSTRB-1:0]      wr_strobe_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_i;
  logic [NUM_REQ-1:0]            wr_gnt_o;
  logic [NUM_REQ-1:0]            rd_req_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_REQ-1:0]            rd_gnt_o;
  logic [NUM_REQ-1:0]            rd_valid_o;
  logic [DATA_WIDTH-1:0]         rd_data_o;
  logic                          ram_we_o;
  logic [NSTRB-1:0]              ram_wstrobe_o;
  logic [ADDR_WIDTH-1:0]         ram_waddr_o;
  logic [DATA_WIDTH-1:0]         ram_wdata_o;
  logic                          ram_re_o;
  logic [ADDR_WIDTH-1:0]         ram_raddr_o;
  logic [DATA_WIDTH-1:0]         ram_rdata_i;

  modport slave (
    input  wr_req_i, wr_strobe_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
           ram_rdata_i,
    output wr_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o, ram_we_o, ram_wstrobe_o,
           ram_waddr_o, ram_wdata_o, ram_re_o, ram_raddr_o
  );

  modport master (
    output wr_req_i, wr_strobe_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
           ram_rdata_i,
    input  wr_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o, ram_we_o, ram_wstrobe_o,
           ram_waddr_o, ram_wdata_o, ram_re_o, ram_raddr_o
  );
endinterface

// File: rtl/abr_be_ram_arb.sv
// -----------------------------------------------------------------------------
// abr_be_ram_arb
// Round-robin arbiter sharing one 1R1W byte-strobed RAM between NUM_REQ
// requesters. Write and read ports are arbitrated independently, each with
// its own round-robin pointer. Grants are combinational; read data returns
// one cycle after the grant with a one-hot per-requester valid.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    abr_be_ram_arb_if.slave (requests, grants, read return, RAM port)
// Optional: define ABR_BE_RAM_ARB_FWD_EN for write-first forwarding when a
// write and a read to the same address are granted in the same cycle.
// -----------------------------------------------------------------------------
module abr_be_ram_arb #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STROBE_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  abr_be_ram_arb_if.slave   bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned NSTRB      = DATA_WIDTH / STROBE_WIDTH;
  localparam int unsigned PW         = $clog2(NUM_REQ);

  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NUM_REQ-1:0]    rd_tag_q;
  logic                  wr_hit, rd_hit, wr_pick, rd_pick;
  logic [PW-1:0]         wr_idx, rd_idx;
  logic [NUM_REQ-1:0]    wr_gnt, rd_gnt;
  logic [NSTRB-1:0]      wstrobe;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] wdata;

  // Two passes: first any requester at or above ptr, then wrap to the lowest
  // index below ptr. Equivalent to a modulo search starting at ptr.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic          hit;
    logic [PW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i] && (i >= 32'(ptr))) begin
        hit = 1'b1;
        idx = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i]) begin
        hit = 1'b1;
        idx = PW'(i);
      end
    end
    return {hit, idx};
  endfunction

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : idx + PW'(1);
  endfunction

  always_comb begin
    {wr_pick, wr_idx} = rr_pick(bus.wr_req_i, wptr_q);
    {rd_pick, rd_idx} = rr_pick(bus.rd_req_i, rptr_q);
    wr_hit = wr_pick && !rst_i;
    rd_hit = rd_pick && !rst_i;
    wr_gnt = wr_hit ? (NUM_REQ'(1) << wr_idx) : '0;
    rd_gnt = rd_hit ? (NUM_REQ'(1) << rd_idx) : '0;
    wptr_d = wr_hit ? nxt_ptr(wr_idx) : wptr_q;
    rptr_d = rd_hit ? nxt_ptr(rd_idx) : rptr_q;
  end

  // Winner's payload mux; all-zero when nothing is granted.
  always_comb begin
    wstrobe = '0;
    waddr   = '0;
    wdata   = '0;
    raddr   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_hit && (wr_idx == PW'(i))) begin
        wstrobe = bus.wr_strobe_i[i*NSTRB +: NSTRB];
        waddr   = bus.wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata   = bus.wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_hit && (rd_idx == PW'(i))) begin
        raddr = bus.rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rd_tag_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rd_tag_q <= rd_gnt;
    end
  end

  assign bus.wr_gnt_o      = wr_gnt;
  assign bus.rd_gnt_o      = rd_gnt;
  assign bus.ram_we_o      = wr_hit;
  assign bus.ram_wstrobe_o = wstrobe;
  assign bus.ram_waddr_o   = waddr;
  assign bus.ram_wdata_o   = wdata;
  assign bus.ram_re_o      = rd_hit;
  assign bus.ram_raddr_o   = raddr;
  // Gated by rst_i so a read outstanding when reset arrives is dropped.
  assign bus.rd_valid_o    = rst_i ? '0 : rd_tag_q;

`ifdef ABR_BE_RAM_ARB_FWD_EN
  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [NSTRB-1:0]      fwd_strb_q;
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
    end else begin
      fwd_hit_q  <= wr_hit && rd_hit && (waddr == raddr);
      fwd_data_q <= wdata;
      fwd_strb_q <= wstrobe;
    end
  end

  always_comb begin
    rdata = bus.ram_rdata_i;
    for (int unsigned l = 0; l < NSTRB; l++) begin
      if (fwd_hit_q && fwd_strb_q[l]) begin
        rdata[l*STROBE_WIDTH +: STROBE_WIDTH] = fwd_data_q[l*STROBE_WIDTH +: STROBE_WIDTH];
      end
    end
  end

  assign bus.rd_data_o = rdata;
`else
  assign bus.rd_data_o = bus.ram_rdata_i;
`endif

endmodule

// File: tb/tb_abr_be_ram_arb.sv
module tb_abr_be_ram_arb;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 8;
  localparam int unsigned AW      = 6;
  localparam int unsigned NS      = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  abr_be_ram_arb_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                      .STROBE_WIDTH(SW)) bus ();

  abr_be_ram_arb #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                   .STROBE_WIDTH(SW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Shared RAM: 1-cycle read latency, read-first on same-address collision.
  logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  assign bus.ram_rdata_i = ram_q;
  always @(posedge clk) begin
    if (bus.ram_re_o) ram_q <= ram_mem[bus.ram_raddr_o];
    if (bus.ram_we_o)
      for (int l = 0; l < NS; l++)
        if (bus.ram_wstrobe_o[l])
          ram_mem[bus.ram_waddr_o][l*SW +: SW] <= bus.ram_wdata_o[l*SW +: SW];
  end

  // Reference model state
  logic [DW-1:0] mmem [DEPTH] = '{default: '0};
  int mwptr = 0;
  int mrptr = 0;
  typedef struct { int req; logic [DW-1:0] data; longint due; } rd_exp_t;
  rd_exp_t rdq[$];
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [NUM_REQ-1:0] req, input int ptr);
    for (int j = 0; j < NUM_REQ; j++) begin
      int k;
      k = (ptr + j) % NUM_REQ;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NS-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < NS; l++) if (strb[l]) r[l*SW +: SW] = nw[l*SW +: SW];
    return r;
  endfunction

  task automatic set_wr(input int k, input logic req, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NS-1:0] s);
    bus.wr_req_i[k]            = req;
    bus.wr_addr_i[k*AW +: AW]  = a;
    bus.wr_data_i[k*DW +: DW]  = d;
    bus.wr_strobe_i[k*NS +: NS] = s;
  endtask

  task automatic set_rd(input int k, input logic req, input logic [AW-1:0] a);
    bus.rd_req_i[k]           = req;
    bus.rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic idle();
    for (int k = 0; k < NUM_REQ; k++) begin
      set_wr(k, 1'b0, '0, '0, '0);
      set_rd(k, 1'b0, '0);
    end
  endtask

  // Inputs are already driven (at a negedge). Check combinational outputs
  // against the model, advance the model, and move to the next negedge.
  task automatic step();
    int wk, rk;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, e;
    logic [NS-1:0] ws;
    rd_exp_t it;
    #1;
    if (rst) begin
      chk("rst_wr_gnt", bus.wr_gnt_o, 0);
      chk("rst_rd_gnt", bus.rd_gnt_o, 0);
      chk("rst_ram_we", bus.ram_we_o, 0);
      chk("rst_ram_re", bus.ram_re_o, 0);
      mwptr = 0;
      mrptr = 0;
    end else begin
      wk = rr(bus.wr_req_i, mwptr);
      rk = rr(bus.rd_req_i, mrptr);
      chk("wr_gnt", bus.wr_gnt_o, (wk >= 0) ? (64'd1 << wk) : 64'd0);
      chk("rd_gnt", bus.rd_gnt_o, (rk >= 0) ? (64'd1 << rk) : 64'd0);
      chk("ram_we", bus.ram_we_o, (wk >= 0) ? 1 : 0);
      chk("ram_re", bus.ram_re_o, (rk >= 0) ? 1 : 0);
      if (wk >= 0) begin
        wa = bus.wr_addr_i[wk*AW +: AW];
        wd = bus.wr_data_i[wk*DW +: DW];
        ws = bus.wr_strobe_i[wk*NS +: NS];
      end else begin
        wa = '0; wd = '0; ws = '0;
      end
      chk("ram_waddr", bus.ram_waddr_o, wa);
      chk("ram_wdata", bus.ram_wdata_o, wd);
      chk("ram_wstrobe", bus.ram_wstrobe_o, ws);
      if (rk >= 0) begin
        ra = bus.rd_addr_i[rk*AW +: AW];
        chk("ram_raddr", bus.ram_raddr_o, ra);
        e = mmem[ra];
`ifdef ABR_BE_RAM_ARB_FWD_EN
        if (wk >= 0 && wa == ra) e = merge(e, wd, ws);
`endif
        it.req = rk; it.data = e; it.due = cyc + 1;
        rdq.push_back(it);
        mrptr = (rk + 1) % NUM_REQ;
      end
      if (wk >= 0) begin
        mmem[wa] = merge(mmem[wa], wd, ws);
        mwptr = (wk + 1) % NUM_REQ;
      end
    end
    @(negedge clk);
  endtask

  // Read-return monitor: pops the scoreboard whenever a response is due.
  initial forever begin
    rd_exp_t it;
    @(negedge clk);
    #2;
    if (rst) begin
      chk("rst_rd_valid", bus.rd_valid_o, 0);
      if (rdq.size() > 0 && rdq[0].due == cyc) it = rdq.pop_front();
    end else if (rdq.size() > 0 && rdq[0].due == cyc) begin
      it = rdq.pop_front();
      chk("rd_valid", bus.rd_valid_o, 64'd1 << it.req);
      chk("rd_data", bus.rd_data_o, it.data);
    end else begin
      chk("idle_rd_valid", bus.rd_valid_o, 0);
    end
  end

  task automatic chk_rd(input string name, input logic [NUM_REQ-1:0] v, input logic [DW-1:0] d);
    #2;
    chk({name, "_valid"}, bus.rd_valid_o, v);
    chk({name, "_data"}, bus.rd_data_o, d);
  endtask

  initial begin
    logic [DW-1:0] conc_exp;
    rst = 1'b1;
    idle();
    // Reset with every request asserted
    for (int k = 0; k < NUM_REQ; k++) begin
      set_wr(k, 1'b1, AW'(k), 32'hFFFF_FFFF, '0);
      set_rd(k, 1'b1, AW'(k));
    end
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rel_wr_gnt", bus.wr_gnt_o, 2'b01);
    chk("rel_rd_gnt", bus.rd_gnt_o, 2'b01);
    step();

    // Fairness from a fresh reset
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_wr(0, 1'b1, 6'd10, $urandom, 4'hF);
      set_wr(1, 1'b1, 6'd11, $urandom, 4'hF);
      #1;
      chk("fair_seq", bus.wr_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    idle();
    set_rd(0, 1'b1, 6'd10);
    set_rd(1, 1'b1, 6'd11);
    step();
    step();
    idle();
    step();

    // Read latency and tag
    set_wr(0, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF);
    step();
    idle();
    set_rd(1, 1'b1, 6'd5);
    #1;
    chk("lat_rd_gnt", bus.rd_gnt_o, 2'b10);
    chk("lat_raddr", bus.ram_raddr_o, 6'd5);
    step();
    idle();
    chk_rd("lat", 2'b10, 32'hDEAD_BEEF);

    // Strobed write
    set_wr(0, 1'b1, 6'd3, 32'h1122_3344, 4'hF);
    step();
    set_wr(0, 1'b1, 6'd3, 32'hAABB_CCDD, 4'b0101);
    step();
    idle();
    set_rd(0, 1'b1, 6'd3);
    step();
    idle();
    chk_rd("strb", 2'b01, 32'h11BB_33DD);

    // Concurrent same-address write and read
    set_wr(0, 1'b1, 6'd7, 32'hFFFF_FFFF, 4'b0011);
    set_rd(1, 1'b1, 6'd7);
    step();
    idle();
`ifdef ABR_BE_RAM_ARB_FWD_EN
    conc_exp = 32'h0000_FFFF;
`else
    conc_exp = 32'h0000_0000;
`endif
    chk_rd("conc", 2'b10, conc_exp);
    step();

    // Reset during the return cycle of a read
    set_rd(0, 1'b1, 6'd5);
    step();
    idle();
    rst = 1'b1;
    chk_rd("midrst", 2'b00, bus.ram_rdata_i);
    step();
    rst = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      set_wr(k, 1'b1, AW'(k), '0, '0);
      set_rd(k, 1'b1, AW'(k));
    end
    #1;
    chk("ptr0_wr", bus.wr_gnt_o, 2'b01);
    chk("ptr0_rd", bus.rd_gnt_o, 2'b01);
    step();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NUM_REQ; k++) begin
        set_wr(k, 1'($urandom), AW'($urandom_range(0, 7)), $urandom, NS'($urandom));
        set_rd(k, 1'($urandom), AW'($urandom_range(0, 7)));
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();
    chk("rdq_drained", rdq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/abr_be_ram_arb.md
Name: abr_be_ram_arb

Overview:
- Round-robin arbiter that shares one 1-read/1-write byte-strobed RAM between NUM_REQ requesters.
- The write port and the read port are arbitrated independently, each with its own round-robin pointer.
- Read latency is 1 cycle; the block tags each read to return a per-requester valid.
- Sits between the ML-DSA/ML-KEM sub-engines (NTT, sampler, hash wrappers) and a shared abr_1r1w_be_ram instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- DEPTH, 64, RAM depth in words.
- DATA_WIDTH, 32, RAM word width in bits.
- STROBE_WIDTH, 8, bits per strobe lane; DATA_WIDTH must be a multiple of it.
- ADDR_WIDTH (localparam), $clog2(DEPTH), address width.
- NSTRB (localparam), DATA_WIDTH/STROBE_WIDTH, strobe lanes per word.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- wr_req_i  in  NUM_REQ  per-requester write request.
- wr_strobe_i  in  NUM_REQ*NSTRB  per-requester lane strobes; requester k occupies slice k.
- wr_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester write address.
- wr_data_i  in  NUM_REQ*DATA_WIDTH  per-requester write data.
- wr_gnt_o  out  NUM_REQ  write grant, one-hot or zero.
- rd_req_i  in  NUM_REQ  per-requester read request.
- rd_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester read address.
- rd_gnt_o  out  NUM_REQ  read grant, one-hot or zero.
- rd_valid_o  out  NUM_REQ  read data valid, one-hot or zero.
- rd_data_o  out  DATA_WIDTH  shared read data.
- ram_we_o  out  1  RAM write enable.
- ram_wstrobe_o  out  NSTRB  RAM lane strobes.
- ram_waddr_o  out  ADDR_WIDTH  RAM write address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_re_o  out  1  RAM read enable.
- ram_raddr_o  out  ADDR_WIDTH  RAM read address.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; valid 1 cycle after ram_re_o.

Behaviour:
- Reset is synchronous, active-high.
  - While rst_i=1, all grants, ram_we_o, ram_re_o and rd_valid_o are 0.
  - Both round-robin pointers reset to 0, so requester 0 has highest priority.
  - The rd_tag register is cleared.
- Grant is combinational in the same cycle. A transfer completes when req & gnt; there is no stall beyond losing arbitration.
- A requester keeps its req and payload stable until granted. A request may be withdrawn before grant; this is legal.
- Round-robin rule:
  - Search order starts at ptr and wraps modulo NUM_REQ.
  - The first requester asserting req wins.
  - On a grant to k, ptr <= (k+1) mod NUM_REQ at the clock edge.
  - With no grant, ptr holds.
  - The write pointer (wptr) and read pointer (rptr) are independent.
- Write path, in the grant cycle:
  - ram_we_o = |wr_gnt_o.
  - ram_wstrobe_o, ram_waddr_o and ram_wdata_o are taken from the winner's slice.
  - With no grant these are driven 0.
  - A write granted with an all-zero strobe is passed through and is a no-op.
- Read path:
  - Grant at cycle N: ram_re_o=1 and ram_raddr_o = winner's address.
  - rd_tag (one-hot) is registered at the edge.
  - At N+1: rd_valid_o = rd_tag, rd_data_o = ram_rdata_i.
  - With no grant at N, rd_valid_o=0 at N+1. rd_data_o then equals ram_rdata_i but is don't-care.
- Back-to-back reads from one requester are allowed: the grant fires every cycle if that requester is alone, giving full throughput of 1 read per cycle.
- Simultaneous write and read to the same address in one cycle: the read returns the pre-write word, unless the optional feature is enabled.
- Reset mid-read: if rst_i is asserted in cycle N+1 of an outstanding read, rd_valid_o=0 and the read is dropped. The requester must reissue it.
- The arbiter applies no address range checks. An address >= DEPTH is forwarded to the RAM unchanged.

Optional Feature:
- Macro: ABR_BE_RAM_ARB_FWD_EN.
- Defined:
  - When a write and a read are granted in the same cycle N with ram_waddr_o == ram_raddr_o, the block registers ram_wdata_o, ram_wstrobe_o and a hit flag.
  - At N+1, rd_data_o lane i = registered wdata lane i if the hit flag is set and strobe[i] is set; otherwise ram_rdata_i lane i.
  - This gives write-first semantics.
- Not defined:
  - No forwarding registers exist; rd_data_o = ram_rdata_i.
  - Same-address concurrent access returns the old data (read-first).

Test Plan:
- Reset: hold rst_i=1 for 3 cycles with all req=1 → all grants, ram_we_o, ram_re_o and rd_valid_o are 0. First cycle after release → wr_gnt_o=rd_gnt_o=2'b01.
- Fairness: NUM_REQ=2, both wr_req held for 6 cycles → wr_gnt_o sequence 01,10,01,10,01,10. RAM holds the last write from each requester at its address.
- Read latency/tag:
  - Preload addr 5=0xDEADBEEF. Requester 1 reads addr 5 at cycle N → rd_gnt_o=2'b10 and ram_raddr_o=5 at N.
  - At N+1: rd_valid_o=2'b10, rd_data_o=0xDEADBEEF.
- Strobed write:
  - Addr 3=0x11223344. Requester 0 writes 0xAABBCCDD with strobe 4'b0101.
  - A later read returns 0x11BB33DD.
- Concurrent same-address access:
  - Addr 7=0x0. Write 0xFFFFFFFF with strobe 4'b0011 to addr 7 while reading addr 7 in the same cycle.
  - rd_data_o=0x00000000 without ABR_BE_RAM_ARB_FWD_EN; 0x0000FFFF with it.
- Reset mid-read: read granted at N, rst_i=1 at N+1 → rd_valid_o=0 at N+1. Both pointers read back as 0 after reset.
